ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder_pkg.sv | 29 ++
 rtl/ram_byte_array.sv | 31 +++
 rtl/ram_responder.sv | 160 ++++++++++++++++
 tb/tb_ram_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_responder_pkg.sv
// Shared encodings for the RAM responder: FSM states, R_W and type field values,
// and the byte-order helper used between the bus word and the storage lanes.
package ram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;
    localparam logic WORD  = 1'b1;
    localparam logic BYTE  = 1'b0;

    localparam int CNT_W = 5;

    // Bus words are big-endian (lowest address in bits 31:24); storage lanes are
    // packed with lane i in bits 8*i+7:8*i. The mapping is its own inverse.
    function automatic logic [31:0] lane_swap(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = d[31-8*i -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Four independent byte lanes with per-lane write enable; lane i holds the bytes
// whose address has bits [1:0] == i. Synchronous write, combinational read.
module ram_byte_array
    import ram_responder_pkg::*;
#(
    parameter int ROWS  = 64,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic [ROW_W-1:0] row,
    input  logic [3:0]       we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [ROWS];

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[row] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = mem[row];
        end
    endgenerate

endmodule

// File: rtl/ram_responder.sv
// Handshaked byte/word RAM slave: latches a request, waits WAIT cycles, performs
// the access on the BUSY->ACK edge and holds MOC until the requester drops MOV.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int WAIT  = 2,
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        MOV,
    input  logic        R_W,
    input  logic        type_sel,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ROWS  = DEPTH / 4;
    localparam int ROW_W = AW - 2;
    // One cycle for the latched request to settle plus WAIT wait states, so
    // MOC rises WAIT+2 edges after the accepting edge.
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT + 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       dout_reg, dout_next;

    logic [AW-1:0]     addr_reg;
    logic [31:0]       wdata_reg;
    logic              rw_reg;
    logic              type_reg;

    logic              commit;
    logic [3:0]        lane_sel;
    logic [3:0]        lane_we;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic [31:0]       word_rdata;
    logic [7:0]        byte_rdata;

    logic              addr_unused;
    assign addr_unused = ^Address[31:AW];

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dout_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dout_reg  <= dout_next;
        end
    end

    // Request fields are captured only on acceptance and held through BUSY/ACK.
    always_ff @(posedge clk) begin
        if (!clear && state_reg == IDLE && MOV) begin
            addr_reg  <= Address[AW-1:0];
            wdata_reg <= DataIn;
            rw_reg    <= R_W;
            type_reg  <= type_sel;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (MOV) begin
                    state_next = BUSY;
                    cnt_next   = WAIT_LOAD;
                end
            end
            BUSY: begin
                // A dropped MOV abandons the request even on its final wait cycle.
                if (!MOV) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = ACK;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ACK: begin
                if (!MOV) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign lane_sel[gi] = (addr_reg[1:0] == 2'(gi));
        end
    endgenerate

    always_comb begin
        lane_we    = '0;
        lane_wdata = lane_swap(wdata_reg);
        if (commit && !clear && rw_reg == WRITE) begin
            case (type_reg)
                WORD: lane_we = 4'hF;
                BYTE: begin
                    lane_we    = lane_sel;
                    lane_wdata = {4{wdata_reg[7:0]}};
                end
            endcase
        end
    end

    always_comb begin
        byte_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (lane_sel[i]) begin
                byte_rdata = lane_rdata[8*i +: 8];
            end
        end
    end

    assign word_rdata = lane_swap(lane_rdata);

    always_comb begin
        dout_next = dout_reg;
        if (commit && rw_reg == READ) begin
            case (type_reg)
                WORD: dout_next = word_rdata;
                BYTE: dout_next = {24'd0, byte_rdata};
            endcase
        end
    end

    ram_byte_array #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_array (
        .clk   (clk),
        .row   (addr_reg[AW-1:2]),
        .we    (lane_we),
        .wdata (lane_wdata),
        .rdata (lane_rdata)
    );

    assign DataOut = dout_reg;
    assign MOC     = (state_reg == ACK);

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed vector table, handshake/abort/
// reset sequences, and random traffic against a byte-array reference model.
module tb_ram_responder;

    localparam int WAIT  = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        clear;
    logic        MOV;
    logic        R_W;
    logic        type_sel;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_mem [DEPTH];
    logic [31:0] dout_model;
    logic [31:0] last_dout;

    typedef struct {
        bit          rw;
        bit          ty;
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    ram_responder #(.WAIT(WAIT), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .clear    (clear),
        .MOV      (MOV),
        .R_W      (R_W),
        .type_sel (type_sel),
        .Address  (Address),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .MOC      (MOC)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference behaviour: flat byte memory, big-endian words, wrap on DEPTH.
    task automatic model_apply(input bit rw, input bit ty, input logic [31:0] addr, input logic [31:0] data);
        int a;
        int base;
        a    = int'(addr % DEPTH);
        base = a - (a % 4);
        if (rw) begin
            if (ty) dout_model = {model_mem[base], model_mem[base+1], model_mem[base+2], model_mem[base+3]};
            else    dout_model = {24'd0, model_mem[a]};
        end else begin
            if (ty) begin
                for (int k = 0; k < 4; k++) model_mem[base+k] = data[31-8*k -: 8];
            end else begin
                model_mem[a] = data[7:0];
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input bit rw, input bit ty, input logic [31:0] addr,
                             input logic [31:0] data, input int hold, input string name);
        int n;
        R_W = rw; type_sel = ty; Address = addr; DataIn = data; MOV = 1'b1;
        tick();
        // Request is latched now; scramble the fields to show they are ignored.
        R_W = 1'($urandom); type_sel = 1'($urandom); Address = $urandom; DataIn = $urandom;
        n = 0;
        while (MOC !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(WAIT + 2));
        for (int k = 0; k < hold; k++) begin
            tick();
            check({name, " hold"}, {31'd0, MOC}, 32'd1);
        end
        MOV = 1'b0;
        tick();
        check({name, " release"}, {31'd0, MOC}, 32'd0);
        model_apply(rw, ty, addr, data);
        check({name, " dout"}, DataOut, dout_model);
        last_dout = DataOut;
        $display("txn %s rw=%0d ty=%0d addr=%h data=%h dout=%h lat=%0d", name, rw, ty, addr, data, DataOut, n);
    endtask

    task automatic abort_access(input bit rw, input bit ty, input logic [31:0] addr,
                                input logic [31:0] data, input string name);
        R_W = rw; type_sel = ty; Address = addr; DataIn = data; MOV = 1'b1;
        tick();
        MOV = 1'b0;
        for (int k = 0; k < WAIT + 3; k++) begin
            tick();
            check({name, " moc"}, {31'd0, MOC}, 32'd0);
        end
        check({name, " dout"}, DataOut, dout_model);
        $display("txn %s aborted rw=%0d ty=%0d addr=%h data=%h dout=%h", name, rw, ty, addr, data, DataOut);
    endtask

    initial begin
        int n;
        clear = 1'b1; MOV = 1'b0; R_W = 1'b0; type_sel = 1'b0; Address = '0; DataIn = '0;
        dout_model = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        repeat (3) tick();
        check("reset moc", {31'd0, MOC}, 32'd0);
        check("reset dout", DataOut, 32'd0);
        clear = 1'b0;
        tick();

        // Fill every word so that all later reads have known contents.
        for (int w = 0; w < DEPTH / 4; w++) begin
            do_access(1'b0, 1'b1, 32'(w * 4), $urandom, 0, "init");
        end

        tbl.push_back('{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        "w_word_10"});
        tbl.push_back('{1'b1, 1'b1, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF, "r_word_10"});
        tbl.push_back('{1'b1, 1'b0, 32'h11,  32'h0,        1'b1, 32'h000000AD, "r_byte_11"});
        tbl.push_back('{1'b0, 1'b0, 32'h13,  32'hFFFFFF55, 1'b1, 32'h000000AD, "w_byte_13"});
        tbl.push_back('{1'b1, 1'b1, 32'h10,  32'h0,        1'b1, 32'hDEADBE55, "r_word_10b"});
        tbl.push_back('{1'b1, 1'b1, 32'h113, 32'h0,        1'b1, 32'hDEADBE55, "r_word_wrap"});
        tbl.push_back('{1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 32'h000000DE, "r_byte_10"});
        tbl.push_back('{1'b1, 1'b0, 32'hF13, 32'h0,        1'b1, 32'h00000055, "r_byte_wrap"});
        tbl.push_back('{1'b0, 1'b1, 32'h22,  32'hA5A50F0F, 1'b1, 32'h00000055, "w_word_22"});
        tbl.push_back('{1'b1, 1'b1, 32'h20,  32'h0,        1'b1, 32'hA5A50F0F, "r_word_20"});
        foreach (tbl[i]) begin
            do_access(tbl[i].rw, tbl[i].ty, tbl[i].addr, tbl[i].data, 0, tbl[i].name);
            if (tbl[i].chk) check({tbl[i].name, " vec"}, last_dout, tbl[i].exp);
        end

        // Write dropped on its first BUSY cycle must leave memory untouched.
        abort_access(1'b0, 1'b1, 32'h20, 32'h12345678, "abort_w_20");
        do_access(1'b1, 1'b1, 32'h20, 32'h0, 0, "r_after_abort");
        check("abort prior content", last_dout, 32'hA5A50F0F);
        abort_access(1'b1, 1'b1, 32'h40, 32'h0, "abort_r_40");

        // Long four-phase hold: MOC stays high, only one access.
        do_access(1'b1, 1'b0, 32'h13, 32'h0, 10, "hold_read");
        check("hold value", last_dout, 32'h00000055);

        // Reset while in ACK of a read.
        R_W = 1'b1; type_sel = 1'b1; Address = 32'h10; MOV = 1'b1;
        n = 0;
        while (MOC !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("ack before clear", {31'd0, MOC}, 32'd1);
        check("ack read value", DataOut, 32'hDEADBE55);
        clear = 1'b1;
        tick();
        check("clear in ack moc", {31'd0, MOC}, 32'd0);
        check("clear in ack dout", DataOut, 32'd0);
        dout_model = '0;
        clear = 1'b0; MOV = 1'b0;
        tick();
        do_access(1'b1, 1'b1, 32'h10, 32'h0, 0, "r_after_clear");
        check("kept after clear", last_dout, 32'hDEADBE55);

        // Reset during BUSY of a write: no commit.
        R_W = 1'b0; type_sel = 1'b1; Address = 32'h30; DataIn = 32'hCAFEF00D; MOV = 1'b1;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0; MOV = 1'b0;
        check("clear in busy moc", {31'd0, MOC}, 32'd0);
        dout_model = '0;
        for (int k = 0; k < WAIT + 3; k++) begin
            tick();
            check("clear in busy idle", {31'd0, MOC}, 32'd0);
        end
        do_access(1'b1, 1'b1, 32'h30, 32'h0, 0, "r_30_after_clear");

        // Request coincident with clear is ignored.
        R_W = 1'b0; type_sel = 1'b1; Address = 32'h34; DataIn = 32'h0BADF00D; MOV = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; MOV = 1'b0;
        for (int k = 0; k < WAIT + 3; k++) begin
            tick();
            check("mov with clear", {31'd0, MOC}, 32'd0);
        end
        do_access(1'b1, 1'b1, 32'h34, 32'h0, 0, "r_34_after_clear");

        // Random traffic against the reference model.
        for (int i = 0; i < 120; i++) begin
            if (i % 10 == 9) begin
                abort_access(1'($urandom), 1'($urandom), $urandom, $urandom, "rand_abort");
            end else begin
                do_access(1'($urandom), 1'($urandom), $urandom, $urandom,
                          int'($urandom_range(0, 3)), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
